// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the fetch front end (package fetch_pkg).
// The FETCH_BYPASS_EN build option is implemented in fetch_queue.
package fetch_pkg;

    localparam int FETCH_DEPTH = 4;
    localparam int INST_W      = 9;
    localparam int ADDR_W      = 12;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry instruction/address storage with head/tail/count.
// A synchronous clear takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = INST_W,
    parameter int D     = ADDR_W,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_inst,
    input  logic [D-1:0]               push_pc,
    input  logic                       pop,
    output logic [W-1:0]               head_inst,
    output logic [D-1:0]               head_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W+D-1:0] mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= {push_inst, push_pc};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot contents stay visible while empty; the top treats them as don't-care.
    assign {head_inst, head_pc} = mem[head];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues one imem read per cycle, queues returns, presents to decode.
// Build option FETCH_BYPASS_EN forwards a returning read straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int D     = ADDR_W,
    parameter int W     = INST_W,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] progCtr,
    input  logic         flush,
    output logic         imemEn,
    output logic [D-1:0] imemAddr,
    input  logic [W-1:0] imemData,
    output logic [W-1:0] instOut,
    output logic [D-1:0] instPc,
    output logic         instValid,
    input  logic         instReady,
    output logic         fetchStall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    logic          pending;
    logic [D-1:0]  reqPc;
    logic [PW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  head_inst;
    logic [D-1:0]  head_pc;
    logic [CW-1:0] occupancy;
    logic          bypass;
    logic          push;
    logic          fifo_pop;

    assign imemAddr = progCtr;

    // Stall counts the in-flight read but not a same-cycle pop, so a return always finds room.
    always_comb begin
        occupancy  = CW'(fifo_count) + CW'(pending);
        fetchStall = !flush && (occupancy >= CW'(DEPTH));
        imemEn     = !reset && !flush && !fetchStall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            reqPc   <= '0;
        end else begin
            pending <= imemEn;
            if (imemEn) reqPc <= progCtr;
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && pending;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        instValid = !fifo_empty || bypass;
        instOut   = bypass ? imemData : head_inst;
        instPc    = bypass ? reqPc    : head_pc;
        fifo_pop  = instValid && instReady && !fifo_empty;
        // A bypassed return that decode takes this cycle never needs a slot.
        push      = pending && !(bypass && instReady);
    end

    fetch_fifo #(
        .W     (W),
        .D     (D),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_inst (imemData),
        .push_pc   (reqPc),
        .pop       (fifo_pop),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model, directed phases plus random traffic.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int D     = ADDR_W;
    localparam int W     = INST_W;
    localparam int DEPTH = FETCH_DEPTH;

    logic         clk = 1'b0;
    logic         reset;
    logic [D-1:0] progCtr;
    logic         flush;
    logic         imemEn;
    logic [D-1:0] imemAddr;
    logic [W-1:0] imemData;
    logic [W-1:0] instOut;
    logic [D-1:0] instPc;
    logic         instValid;
    logic         instReady;
    logic         fetchStall;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [D-1:0] exp_q[$];
    bit           inflight;
    logic [D-1:0] inflight_pc;
    logic [D-1:0] pc;
    logic [D-1:0] flush_pc;

    fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .progCtr    (progCtr),
        .flush      (flush),
        .imemEn     (imemEn),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .instOut    (instOut),
        .instPc     (instPc),
        .instValid  (instValid),
        .instReady  (instReady),
        .fetchStall (fetchStall)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_f(input logic [D-1:0] a);
        return a[8:0] ^ {a[11:9], a[11:9], a[11:9]} ^ 9'h15A;
    endfunction

    // instruction memory: one-cycle synchronous read
    always @(posedge clk) begin
        if (imemEn) imemData <= mem_f(imemAddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        inflight    = 1'b0;
        inflight_pc = '0;
    endtask

    // One clock cycle: drive, check at mid-cycle, advance the model across the edge.
    task automatic step(input logic rdy, input logic fl);
        int           cnt;
        bit           ev, es, en, byp, consumed;
        logic [D-1:0] hpc;
        instReady = rdy;
        flush     = fl;
        progCtr   = pc;
        #1;
        cnt = exp_q.size();
        es  = !fl && ((cnt + int'(inflight)) >= DEPTH);
        en  = !fl && !es;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (cnt == 0) && inflight;
`endif
        ev  = (cnt > 0) || byp;
        hpc = (cnt > 0) ? exp_q[0] : inflight_pc;
        chk("imemEn", 32'(imemEn), 32'(en));
        chk("fetchStall", 32'(fetchStall), 32'(es));
        chk("imemAddr", 32'(imemAddr), 32'(pc));
        chk("instValid", 32'(instValid), 32'(ev));
        chk("count", 32'(dut.fifo_count), 32'(cnt));
        if (ev) begin
            chk("instPc", 32'(instPc), 32'(hpc));
            chk("instOut", 32'(instOut), 32'(mem_f(hpc)));
        end
        @(posedge clk);
        consumed = 1'b0;
        if (fl) begin
            model_clear();
        end else begin
            if (ev && rdy) begin
                if (cnt > 0) void'(exp_q.pop_front());
                else consumed = 1'b1;
            end
            if (inflight && !consumed) exp_q.push_back(inflight_pc);
        end
        inflight = en;
        if (en) inflight_pc = pc;
        if (fl) pc = flush_pc;
        else if (en) pc = pc + 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        instReady = 1'b0;
        progCtr   = '0;
        pc        = '0;
        flush_pc  = 12'h040;
        model_clear();
        #1;
        chk("rst_imemEn", 32'(imemEn), 32'd0);
        chk("rst_fetchStall", 32'(fetchStall), 32'd0);
        chk("rst_instValid", 32'(instValid), 32'd0);
        chk("rst_count", 32'(dut.fifo_count), 32'd0);
        chk("rst_pending", 32'(dut.pending), 32'd0);
        chk("rst_reqPc", 32'(dut.reqPc), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // backpressure from the first cycle: queue fills to DEPTH then holds
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("bp_count_full", 32'(dut.fifo_count), 32'(DEPTH));
        chk("bp_head_pc", 32'(instPc), 32'd0);

        // drain and continue streaming
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);

        // fill to three entries, then flush with one read in flight
        for (int i = 0; i < 10 && exp_q.size() < 3; i++) step(1'b0, 1'b0);
        chk("pre_flush_count", 32'(dut.fifo_count), 32'd3);
        flush_pc = 12'h040;
        step(1'b0, 1'b1);
        chk("post_flush_count", 32'(dut.fifo_count), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

        // pointer wrap with alternating ready
        for (int i = 0; i < 6 * DEPTH; i++) step(1'(i % 2 == 0), 1'b0);

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            flush_pc = 12'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        // asynchronous reset between edges with three queued entries
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12 && exp_q.size() < 3; i++) step(1'b0, 1'b0);
        chk("pre_reset_count", 32'(dut.fifo_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_imemEn", 32'(imemEn), 32'd0);
        chk("arst_fetchStall", 32'(fetchStall), 32'd0);
        chk("arst_instValid", 32'(instValid), 32'd0);
        chk("arst_count", 32'(dut.fifo_count), 32'd0);
        chk("arst_pending", 32'(dut.pending), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        pc = 12'h100;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
